// File: rtl/udma_sdio_evt_arb.sv
// -----------------------------------------------------------------------------
// udma_sdio_evt_arb
//
// Collects end-of-transfer and error pulses from NB_CH SDIO channels into
// per-channel saturating counters. A single-entry output register presents
// one event at a time. Channels take turns in round-robin order, and within
// a channel an error event is served before an EOT event.
//
// Parameters
//   NB_CH  number of channels (1..16)
//   CNT_W  width of each pending counter (1..8)
//   CH_W   derived channel-index width, max(1, $clog2(NB_CH))
//
// Ports
//   sys_clk_i    clock
//   rst_i        synchronous active-high reset
//   eot_i        per-channel end-of-transfer pulse
//   err_i        per-channel error pulse
//   clr_i        per-channel flush of both pending counters
//   evt_valid_o  event presented
//   evt_ready_i  downstream accepts the presented event
//   evt_ch_o     channel of the presented event
//   evt_err_o    1 = error event, 0 = EOT event
//   pending_o    per-channel "any count non-zero"
//   ovf_o        sticky per-channel overflow (only with SDIO_EVT_OVF_EN)
//
// Optional feature macro: SDIO_EVT_OVF_EN
// -----------------------------------------------------------------------------
module udma_sdio_evt_arb #(
    parameter int  NB_CH = 4,
    parameter int  CNT_W = 4,
    localparam int CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic [NB_CH-1:0] eot_i,
    input  logic [NB_CH-1:0] err_i,
    input  logic [NB_CH-1:0] clr_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [CH_W-1:0]  evt_ch_o,
    output logic             evt_err_o,
    output logic [NB_CH-1:0] pending_o
`ifdef SDIO_EVT_OVF_EN
    ,
    output logic [NB_CH-1:0] ovf_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] eot_cnt [NB_CH];
    logic [CNT_W-1:0] err_cnt [NB_CH];

    // Channel loaded most recently; the search starts just after it.
    logic [CH_W-1:0]  last_ch;

    logic             load;
    logic             take;
    logic             any_pending;
    logic             hi_found;
    logic [CH_W-1:0]  hi_ch;
    logic [CH_W-1:0]  lo_ch;
    logic [CH_W-1:0]  sel_ch;
    logic             sel_err;
    logic [NB_CH-1:0] dec_eot;
    logic [NB_CH-1:0] dec_err;

    // Saturating up/down counter step; clear dominates everything.
    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec,
        input logic             clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && !dec) begin
            return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        if (dec && !inc) begin
            return cnt - 1'b1;
        end
        return cnt;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        pending_o = '0;
        for (int i = 0; i < NB_CH; i++) begin
            pending_o[i] = (eot_cnt[i] != '0) || (err_cnt[i] != '0);
        end
    end

    // The output register may load when empty or when its event is taken.
    assign load = !evt_valid_o || evt_ready_i;
    assign take = load && any_pending;

    // Round-robin pick: lowest pending channel above last_ch, otherwise wrap
    // to the lowest pending channel at or below it. Scanning downwards lets
    // the last match win, which is the lowest index in each half.
    always_comb begin
        any_pending = 1'b0;
        hi_found    = 1'b0;
        hi_ch       = '0;
        lo_ch       = '0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (pending_o[i]) begin
                any_pending = 1'b1;
                if (i > int'(last_ch)) begin
                    hi_found = 1'b1;
                    hi_ch    = CH_W'(i);
                end else begin
                    lo_ch = CH_W'(i);
                end
            end
        end
        sel_ch = hi_found ? hi_ch : lo_ch;

        // Errors are served before EOTs on the chosen channel.
        sel_err = 1'b0;
        for (int i = 0; i < NB_CH; i++) begin
            if (CH_W'(i) == sel_ch) begin
                sel_err = (err_cnt[i] != '0);
            end
        end

        dec_eot = '0;
        dec_err = '0;
        for (int i = 0; i < NB_CH; i++) begin
            dec_err[i] = take && (CH_W'(i) == sel_ch) && sel_err;
            dec_eot[i] = take && (CH_W'(i) == sel_ch) && !sel_err;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every register samples pre-edge values regardless of order.
            evt_valid_o <= 1'b0;
            evt_ch_o    <= '0;
            evt_err_o   <= 1'b0;
            last_ch     <= CH_W'(NB_CH - 1);
            // NOTE: the counter arrays are small flop banks, not RAM, so they
            // are reset explicitly; pending work must never survive reset.
            for (int i = 0; i < NB_CH; i++) begin
                eot_cnt[i] <= '0;
                err_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_CH; i++) begin
                eot_cnt[i] <= next_cnt(eot_cnt[i], eot_i[i], dec_eot[i], clr_i[i]);
                err_cnt[i] <= next_cnt(err_cnt[i], err_i[i], dec_err[i], clr_i[i]);
            end
            if (load) begin
                evt_valid_o <= any_pending;
                if (any_pending) begin
                    evt_ch_o  <= sel_ch;
                    evt_err_o <= sel_err;
                    last_ch   <= sel_ch;
                end
            end
        end
    end

`ifdef SDIO_EVT_OVF_EN
    // A pulse is lost only when it lands on a full counter with no
    // concurrent decrement or flush.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            ovf_o <= '0;
        end else begin
            for (int i = 0; i < NB_CH; i++) begin
                if ((eot_i[i] && !dec_eot[i] && !clr_i[i] && (eot_cnt[i] == CNT_MAX)) ||
                    (err_i[i] && !dec_err[i] && !clr_i[i] && (err_cnt[i] == CNT_MAX))) begin
                    ovf_o[i] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_udma_sdio_evt_arb.sv
// -----------------------------------------------------------------------------
// Testbench for udma_sdio_evt_arb (NB_CH=4, CNT_W=2).
// A behavioural model (integer counters, round-robin search by modulo) steps
// on every rising edge; a compare process checks the DUT against it on every
// falling edge. Directed scenarios add literal expectations at fixed cycles.
// -----------------------------------------------------------------------------
module tb_udma_sdio_evt_arb;

    localparam int NB   = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [NB-1:0] eot;
    logic [NB-1:0] err;
    logic [NB-1:0] clr;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_ch;
    logic          evt_err;
    logic [NB-1:0] pending;
`ifdef SDIO_EVT_OVF_EN
    logic [NB-1:0] ovf;
`endif

    int total = 0;
    int bad   = 0;

    udma_sdio_evt_arb #(.NB_CH(NB), .CNT_W(CW)) dut (
        .sys_clk_i   (clk),
        .rst_i       (rst),
        .eot_i       (eot),
        .err_i       (err),
        .clr_i       (clr),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_ch_o    (evt_ch),
        .evt_err_o   (evt_err),
        .pending_o   (pending)
`ifdef SDIO_EVT_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_eot [NB];
    int m_err [NB];
    bit m_valid;
    int m_ch;
    bit m_err_o;
    int m_last;
    bit m_ok = 0;
`ifdef SDIO_EVT_OVF_EN
    bit [NB-1:0] m_ovf;
`endif

    task automatic model_step();
        int  dec_ch;
        bit  dec_is_err;
        bit  found;
        int  c;
        int  n;
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                m_eot[k] = 0;
                m_err[k] = 0;
            end
            m_valid = 0;
            m_ch    = 0;
            m_err_o = 0;
            m_last  = NB - 1;
`ifdef SDIO_EVT_OVF_EN
            m_ovf   = '0;
`endif
            m_ok    = 1;
            return;
        end
        dec_ch     = -1;
        dec_is_err = 0;
        if (!m_valid || evt_ready) begin
            found = 0;
            for (int k = 1; k <= NB; k++) begin
                c = (m_last + k) % NB;
                if (!found && (m_eot[c] + m_err[c]) > 0) begin
                    found      = 1;
                    dec_ch     = c;
                    dec_is_err = (m_err[c] > 0);
                end
            end
            m_valid = found;
            if (found) begin
                m_ch    = dec_ch;
                m_err_o = dec_is_err;
                m_last  = dec_ch;
            end
        end
        for (int k = 0; k < NB; k++) begin
            if (clr[k]) begin
                m_eot[k] = 0;
                m_err[k] = 0;
            end else begin
                n = m_eot[k] + int'(eot[k]) - ((dec_ch == k && !dec_is_err) ? 1 : 0);
                if (n > MAXC) begin
                    n = MAXC;
`ifdef SDIO_EVT_OVF_EN
                    m_ovf[k] = 1'b1;
`endif
                end
                m_eot[k] = n;
                n = m_err[k] + int'(err[k]) - ((dec_ch == k && dec_is_err) ? 1 : 0);
                if (n > MAXC) begin
                    n = MAXC;
`ifdef SDIO_EVT_OVF_EN
                    m_ovf[k] = 1'b1;
`endif
                end
                m_err[k] = n;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [NB-1:0] exp_pend;
        forever begin
            @(negedge clk);
            if (m_ok) begin
                for (int k = 0; k < NB; k++) begin
                    exp_pend[k] = (m_eot[k] + m_err[k]) > 0;
                end
                check("model_valid", 32'(evt_valid), 32'(m_valid));
                check("model_pending", 32'(pending), 32'(exp_pend));
                if (m_valid) begin
                    check("model_ch", 32'(evt_ch), 32'(m_ch));
                    check("model_err", 32'(evt_err), 32'(m_err_o));
                end
`ifdef SDIO_EVT_OVF_EN
                check("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        rst = 1'b1;
        eot = '0;
        err = '0;
        clr = '0;
        @(negedge clk);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int delivered;
        int ch3_seen;
        rst       = 1'b1;
        eot       = '0;
        err       = '0;
        clr       = '0;
        evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid0", 32'(evt_valid), 32'd0);
        check("rst_ch0", 32'(evt_ch), 32'd0);
        check("rst_err0", 32'(evt_err), 32'd0);
        check("rst_pending0", 32'(pending), 32'd0);
        rst = 1'b0;

        // Single EOT on channel 2: valid exactly in cycle 2.
        eot = 4'b0100;
        @(negedge clk);
        eot = '0;
        check("s1_c1_valid", 32'(evt_valid), 32'd0);
        check("s1_c1_pending", 32'(pending), 32'h4);
        @(negedge clk);
        check("s1_c2_valid", 32'(evt_valid), 32'd1);
        check("s1_c2_ch", 32'(evt_ch), 32'd2);
        check("s1_c2_err", 32'(evt_err), 32'd0);
        check("s1_c2_pending", 32'(pending), 32'd0);
        @(negedge clk);
        check("s1_c3_valid", 32'(evt_valid), 32'd0);

        // All channels, both kinds at once: errors first, then EOTs.
        do_reset();
        eot = 4'hF;
        err = 4'hF;
        @(negedge clk);
        eot = '0;
        err = '0;
        check("s2_pending", 32'(pending), 32'hF);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("s2_valid", 32'(evt_valid), 32'd1);
            check("s2_ch", 32'(evt_ch), 32'(j % 4));
            check("s2_err", 32'(evt_err), (j < 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("s2_drain", 32'(evt_valid), 32'd0);

        // Back-pressure for 5 cycles, then back-to-back load.
        do_reset();
        evt_ready = 1'b0;
        eot = 4'b0011;
        @(negedge clk);
        eot = '0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("s3_hold_valid", 32'(evt_valid), 32'd1);
            check("s3_hold_ch", 32'(evt_ch), 32'd0);
            check("s3_hold_err", 32'(evt_err), 32'd0);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        check("s3_next_valid", 32'(evt_valid), 32'd1);
        check("s3_next_ch", 32'(evt_ch), 32'd1);
        @(negedge clk);
        check("s3_empty", 32'(evt_valid), 32'd0);

        // Saturation: 5 pulses into a 2-bit counter while stalled.
        do_reset();
        evt_ready = 1'b0;
        eot = 4'b0010;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
        end
        eot = '0;
        check("s4_pending", 32'(pending), 32'h2);
        check("s4_ch", 32'(evt_ch), 32'd1);
`ifdef SDIO_EVT_OVF_EN
        check("s4_ovf", 32'(ovf), 32'h2);
`endif
        evt_ready = 1'b1;
        delivered = 0;
        for (int j = 0; j < 10; j++) begin
            if (evt_valid && evt_ch == 2'd1) delivered++;
            @(negedge clk);
        end
        check("s4_delivered", 32'(delivered), 32'd4);
        check("s4_drained", 32'(pending), 32'd0);
`ifdef SDIO_EVT_OVF_EN
        check("s4_ovf_sticky", 32'(ovf), 32'h2);
`endif

        // Flush of channel 3 beats a simultaneous error pulse.
        do_reset();
`ifdef SDIO_EVT_OVF_EN
        check("s5_ovf_cleared", 32'(ovf), 32'd0);
`endif
        evt_ready = 1'b0;
        eot = 4'b0001;
        @(negedge clk);
        eot = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        check("s5_pending_before", 32'(pending), 32'h8);
        eot = '0;
        clr = 4'b1000;
        err = 4'b1000;
        @(negedge clk);
        clr = '0;
        err = '0;
        check("s5_pending_after", 32'(pending), 32'd0);
        check("s5_kept_valid", 32'(evt_valid), 32'd1);
        check("s5_kept_ch", 32'(evt_ch), 32'd0);
        evt_ready = 1'b1;
        ch3_seen = 0;
        for (int j = 0; j < 8; j++) begin
            if (evt_valid && evt_ch == 2'd3) ch3_seen++;
            @(negedge clk);
        end
        check("s5_no_ch3", 32'(ch3_seen), 32'd0);

        // Reset mid-handshake with 6 counts pending; pulses during reset ignored.
        do_reset();
        evt_ready = 1'b0;
        eot = 4'hF;
        err = 4'b0011;
        @(negedge clk);
        eot = 4'b0100;
        err = '0;
        @(negedge clk);
        check("s6_pre_valid", 32'(evt_valid), 32'd1);
        check("s6_pre_pending", 32'(pending), 32'hF);
        rst = 1'b1;
        eot = 4'b0010;
        @(negedge clk);
        check("s6_rst_valid", 32'(evt_valid), 32'd0);
        check("s6_rst_ch", 32'(evt_ch), 32'd0);
        check("s6_rst_err", 32'(evt_err), 32'd0);
        check("s6_rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        evt_ready = 1'b1;
        eot = 4'b1001;
        @(negedge clk);
        eot = '0;
        @(negedge clk);
        check("s6_first_valid", 32'(evt_valid), 32'd1);
        check("s6_first_ch", 32'(evt_ch), 32'd0);
        @(negedge clk);
        check("s6_second_ch", 32'(evt_ch), 32'd3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udma_sdio_evt_arb.md
UDMA_SDIO_EVT_ARB -- requirements
Module: udma_sdio_evt_arb

Interface
REQ-001 Parameter NB_CH, default 4, SHALL set the number of SDIO channels whose events are aggregated (legal range 1..16).
REQ-002 Parameter CNT_W, default 4, SHALL set the width of each per-channel, per-type pending counter (legal range 1..8).
REQ-003 Parameter CH_W SHALL be derived, not overridden: CH_W = max(1, $clog2(NB_CH)).
REQ-004 sys_clk_i  input  1  single clock for the block.
REQ-005 rst_i  input  1  reset, synchronous to sys_clk_i, active-high.
REQ-006 eot_i  input  NB_CH  per-channel end-of-transfer pulse, one-cycle.
REQ-007 err_i  input  NB_CH  per-channel error pulse, one-cycle.
REQ-008 clr_i  input  NB_CH  per-channel flush of pending counts.
REQ-009 evt_valid_o  output  1  event available.
REQ-010 evt_ready_i  input  1  downstream accepts the event.
REQ-011 evt_ch_o  output  CH_W  channel index of the presented event.
REQ-012 evt_err_o  output  1  1 = error event, 0 = EOT event.
REQ-013 pending_o  output  NB_CH  bit i = 1 while either counter of channel i is non-zero.
REQ-014 ovf_o  output  NB_CH  sticky overflow flag per channel (present only when SDIO_EVT_OVF_EN is defined).

Function
REQ-015 Each channel SHALL hold two CNT_W-bit counters, eot_cnt[i] and err_cnt[i], incremented by eot_i[i] and err_i[i] respectively.
REQ-016 A counter at 2^CNT_W-1 SHALL saturate, and a further pulse SHALL be dropped.
REQ-017 A simultaneous increment and decrement on the same counter SHALL leave it unchanged.
REQ-018 The output stage SHALL be a single register (evt_valid_o, evt_ch_o, evt_err_o) that loads when evt_valid_o=0 or (evt_valid_o & evt_ready_i).
REQ-019 On load, the arbiter SHALL pick one channel with a non-zero counter, round-robin, starting at the channel after the last loaded one.
REQ-020 Within the chosen channel, err SHALL take priority over eot.
REQ-021 The chosen counter SHALL decrement on the same edge as the load.
REQ-022 The round-robin pointer SHALL advance only on a load.
REQ-023 If no counter is non-zero at a load opportunity, evt_valid_o SHALL go to 0.
REQ-024 While evt_valid_o=1 and evt_ready_i=0, evt_valid_o, evt_ch_o and evt_err_o SHALL hold stable.
REQ-025 Latency: a pulse at edge t SHALL update the counter at t+1, and SHALL produce evt_valid_o=1 at t+2 when the output stage is free and there is no other pending work.
REQ-026 Throughput SHALL be one event per cycle when evt_ready_i is held at 1.
REQ-027 clr_i[i] SHALL zero both counters of channel i on the next edge and SHALL win over a simultaneous pulse or decrement on that channel.
REQ-028 clr_i[i] SHALL NOT retract an event already in the output register, and SHALL NOT clear ovf_o[i].
REQ-029 With NB_CH=1, evt_ch_o SHALL be constant 0.
REQ-030 pending_o SHALL be derived combinationally from the counters.

Reset
REQ-031 On rst_i=1 at an edge, all counters SHALL clear to 0.
REQ-032 On the same reset, evt_valid_o, evt_ch_o and evt_err_o SHALL clear to 0.
REQ-033 On the same reset, the round-robin pointer SHALL return so that channel 0 wins first.
REQ-034 On the same reset, ovf_o SHALL clear to 0.
REQ-035 Reset mid-handshake SHALL discard the presented event without requiring evt_ready_i.
REQ-036 Pulses arriving while rst_i=1 SHALL be ignored.

Configuration
REQ-037 Macro SDIO_EVT_OVF_EN defined: ovf_o[i] SHALL set on any dropped pulse of channel i (REQ-016) and SHALL clear only on reset.
REQ-038 Macro SDIO_EVT_OVF_EN undefined: the ovf_o port and its logic SHALL be absent, and saturation behaviour SHALL be unchanged.

Verification
REQ-039 Scenario: NB_CH=4, evt_ready_i=1, single eot_i[2] pulse at cycle 0 -> evt_valid_o=1, evt_ch_o=2, evt_err_o=0 for exactly cycle 2; pending_o=0 from cycle 2.
REQ-040 Scenario: eot_i and err_i on all 4 channels in the same cycle, ready=1 -> 8 events on consecutive cycles: ch0 err, ch1 err, ch2 err, ch3 err, ch0 eot, ch1 eot, ch2 eot, ch3 eot.
REQ-041 Scenario: evt_ready_i=0 for 5 cycles with an event presented -> outputs stable all 5 cycles; the accepting cycle loads the next event with no gap.
REQ-042 Scenario: CNT_W=2, 5 eot_i[1] pulses while ready=0 -> counter saturates at 3; 4 events total delivered (1 registered + 3 counted); ovf_o[1]=1 with the macro defined.
REQ-043 Scenario: clr_i[3] on the same cycle as err_i[3], with ch3 eot_cnt=2 -> both counters 0 next cycle; no ch3 events delivered afterwards.
REQ-044 Scenario: rst_i asserted while evt_valid_o=1 and 6 counts pending -> next cycle all outputs 0; first post-reset event from channel 0 if pending.
